breakout_game_ctrl: RTL and testbench

//  Game-state controller for Breakout. Sits downstream of pong_graph and consumes its hit/miss flags.

---
 rtl/breakout_game_ctrl_pkg.sv | 23 ++
 rtl/breakout_game_ctrl_bcd2_counter.sv | 31 +++
 rtl/breakout_game_ctrl.sv | 163 ++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/breakout_game_ctrl_pkg.sv
// Shared state encoding and BCD helper for the Breakout game controller.
package breakout_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_bcd2_counter.sv
// Two-digit BCD score counter, saturating at 99; clr wins over inc.
module bcd2_counter
    import breakout_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);

    logic [7:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = 8'h00;
        else if (inc)
            q_d = bcd_inc(q_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            q_q <= 8'h00;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game-state controller: input conditioning, game FSM, ball budget, BCD score.
// Optional high-score register enabled by defining BREAKOUT_HISCORE_EN.
//
// state      | meaning
// NEWGAME    | waiting for start key, motion frozen, ball budget full
// PLAY       | ball in motion, hits score, misses cost a ball
// NEWBALL    | hold after a miss, start key accepted once timer expires
// OVER       | last ball lost, hold then return to NEWGAME
module breakout_game_ctrl
    import breakout_game_ctrl_pkg::*;
#(
    parameter int unsigned             BALLS    = 3,
    parameter int unsigned             WAIT_W   = 28,
    parameter logic [WAIT_W-1:0]       WAIT_CYC = WAIT_W'(200_000_000)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key_start,
    input  logic        hit,
    input  logic        miss,
    output logic        gra_still,
    output logic [1:0]  state,
    output logic [3:0]  ball_left,
    output logic [7:0]  score,
    output logic [31:0] seg_data
);

    localparam logic [3:0] BALLS_L = 4'(BALLS);

    // Bit order in the conditioning vectors: {key_start, hit, miss}.
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, pulse_q, pulse_d;

    always_comb begin
        sync1_d = {key_start, hit, miss};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            pulse_q <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    logic key_p, hit_p, miss_p;
    assign {key_p, hit_p, miss_p} = pulse_q;

    state_t              state_q, state_d;
    logic [3:0]          ball_left_q, ball_left_d;
    logic [WAIT_W-1:0]   timer_q, timer_d;
    logic                gra_still_q, gra_still_d;
    logic                score_clr, score_inc;
    logic [7:0]          score_q;

    always_comb begin
        state_d     = state_q;
        ball_left_d = ball_left_q;
        timer_d     = timer_q;
        score_clr   = 1'b0;
        score_inc   = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                ball_left_d = BALLS_L;
                if (key_p) begin
                    state_d   = ST_PLAY;
                    score_clr = 1'b1;
                end
            end
            ST_PLAY: begin
                score_inc = hit_p;
                if (miss_p) begin
                    timer_d = WAIT_CYC;
                    if (ball_left_q > 4'd1) begin
                        ball_left_d = ball_left_q - 4'd1;
                        state_d     = ST_NEWBALL;
                    end else begin
                        ball_left_d = 4'd0;
                        state_d     = ST_OVER;
                    end
                end
            end
            ST_NEWBALL: begin
                if (timer_q != '0)
                    timer_d = timer_q - WAIT_W'(1);
                else if (key_p)
                    state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - WAIT_W'(1);
                end else begin
                    state_d     = ST_NEWGAME;
                    ball_left_d = BALLS_L;
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
        gra_still_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_NEWGAME;
            ball_left_q <= BALLS_L;
            timer_q     <= '0;
            gra_still_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ball_left_q <= ball_left_d;
            timer_q     <= timer_d;
            gra_still_q <= gra_still_d;
        end
    end

    bcd2_counter u_score (
        .clk  (clk),
        .rstn (rstn),
        .clr  (score_clr),
        .inc  (score_inc),
        .q    (score_q)
    );

    logic [7:0] hi_disp;

`ifdef BREAKOUT_HISCORE_EN
    logic [7:0] hi_score_q, hi_score_d, score_nx;

    // Compare against the score as it will be after this edge, so a hit on the losing cycle counts.
    always_comb begin
        score_nx   = score_inc ? bcd_inc(score_q) : score_q;
        hi_score_d = hi_score_q;
        if (state_q == ST_PLAY && state_d == ST_OVER && score_nx > hi_score_q)
            hi_score_d = score_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            hi_score_q <= 8'h00;
        else
            hi_score_q <= hi_score_d;
    end

    assign hi_disp = hi_score_q;
`else
    assign hi_disp = 8'h00;
`endif

    assign gra_still = gra_still_q;
    assign state     = state_q;
    assign ball_left = ball_left_q;
    assign score     = score_q;
    assign seg_data  = {8'h00, hi_disp, 4'h0, ball_left_q, score_q};

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed self-checking bench for breakout_game_ctrl (BALLS=3, WAIT_CYC=16).
module tb_breakout_game_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        key_start, hit, miss;
    logic        gra_still;
    logic [1:0]  state;
    logic [3:0]  ball_left;
    logic [7:0]  score;
    logic [31:0] seg_data;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] S_NG = 2'b00, S_PL = 2'b01, S_NB = 2'b10, S_OV = 2'b11;

    breakout_game_ctrl #(
        .BALLS    (3),
        .WAIT_W   (28),
        .WAIT_CYC (28'd16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_start (key_start),
        .hit       (hit),
        .miss      (miss),
        .gra_still (gra_still),
        .state     (state),
        .ball_left (ball_left),
        .score     (score),
        .seg_data  (seg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_key();
        key_start = 1'b1; cyc(1); key_start = 1'b0; cyc(3);
    endtask

    task automatic pulse_hit();
        hit = 1'b1; cyc(1); hit = 1'b0; cyc(3);
    endtask

    task automatic pulse_miss();
        miss = 1'b1; cyc(1); miss = 1'b0; cyc(3);
    endtask

    task automatic wait_state(input logic [1:0] exp, input int max_cyc, input string tag);
        int i;
        i = 0;
        while (state !== exp && i < max_cyc) begin
            cyc(1);
            i++;
        end
        chk(tag, {30'd0, state}, {30'd0, exp});
    endtask

    initial begin
        rstn = 1'b0; key_start = 1'b0; hit = 1'b0; miss = 1'b0;
        cyc(2);
        chk("rst_state", {30'd0, state}, {30'd0, S_NG});
        chk("rst_score", {24'd0, score}, 32'h00);
        chk("rst_balls", {28'd0, ball_left}, 32'd3);
        chk("rst_still", {31'd0, gra_still}, 32'd1);
        chk("rst_seg", seg_data, 32'h0000_0300);
        rstn = 1'b1;
        cyc(2);

        // key held 10 cycles: exactly one transition, three edges after first sample
        key_start = 1'b1;
        cyc(3);
        chk("key_lat_early", {30'd0, state}, {30'd0, S_NG});
        cyc(1);
        chk("key_to_play", {30'd0, state}, {30'd0, S_PL});
        chk("play_still", {31'd0, gra_still}, 32'd0);
        chk("play_score", {24'd0, score}, 32'h00);
        cyc(6);
        key_start = 1'b0;
        cyc(4);
        chk("key_in_play", {30'd0, state}, {30'd0, S_PL});

        // long hit level counts once
        hit = 1'b1;
        cyc(50);
        hit = 1'b0;
        cyc(4);
        chk("hit_level", {24'd0, score}, 32'h01);
        repeat (4) pulse_hit();
        chk("score_05", {24'd0, score}, 32'h05);

        // asynchronous reset mid-PLAY
        rstn = 1'b0;
        #1;
        chk("mid_rst_state", {30'd0, state}, {30'd0, S_NG});
        chk("mid_rst_score", {24'd0, score}, 32'h00);
        chk("mid_rst_balls", {28'd0, ball_left}, 32'd3);
        chk("mid_rst_still", {31'd0, gra_still}, 32'd1);
        cyc(1);
        rstn = 1'b1;
        cyc(2);

        pulse_key();
        chk("restart_play", {30'd0, state}, {30'd0, S_PL});
        repeat (9) pulse_hit();
        chk("score_09", {24'd0, score}, 32'h09);
        pulse_hit();
        chk("score_10", {24'd0, score}, 32'h10);
        repeat (2) pulse_hit();
        chk("score_12", {24'd0, score}, 32'h12);
        chk("seg_12", seg_data, 32'h0000_0312);

        // miss -> NEWBALL; early key and hit are dropped
        pulse_miss();
        chk("nb_state", {30'd0, state}, {30'd0, S_NB});
        chk("nb_balls", {28'd0, ball_left}, 32'd2);
        chk("nb_still", {31'd0, gra_still}, 32'd1);
        pulse_key();
        chk("nb_early_key", {30'd0, state}, {30'd0, S_NB});
        pulse_hit();
        chk("nb_hit_drop", {24'd0, score}, 32'h12);
        cyc(12);
        pulse_key();
        chk("nb_key_play", {30'd0, state}, {30'd0, S_PL});
        chk("nb_play_still", {31'd0, gra_still}, 32'd0);

        pulse_miss();
        chk("nb2_balls", {28'd0, ball_left}, 32'd1);
        cyc(20);
        pulse_key();
        chk("nb2_play", {30'd0, state}, {30'd0, S_PL});

        // last miss -> OVER, then timed return to NEWGAME
        pulse_miss();
        chk("over_state", {30'd0, state}, {30'd0, S_OV});
        chk("over_balls", {28'd0, ball_left}, 32'd0);
        cyc(16);
        chk("over_hold", {30'd0, state}, {30'd0, S_OV});
        cyc(1);
        chk("over_to_ng", {30'd0, state}, {30'd0, S_NG});
        chk("ng_balls", {28'd0, ball_left}, 32'd3);
        chk("ng_score_kept", {24'd0, score}, 32'h12);
`ifdef BREAKOUT_HISCORE_EN
        chk("hiscore", {24'd0, seg_data[23:16]}, 32'h12);
`else
        chk("hiscore_off", {24'd0, seg_data[23:16]}, 32'h00);
`endif

        // simultaneous hit and miss on the last ball
        pulse_key();
        chk("g2_score_clr", {24'd0, score}, 32'h00);
        repeat (7) pulse_hit();
        repeat (2) begin
            pulse_miss();
            cyc(20);
            pulse_key();
        end
        chk("g2_ball1", {28'd0, ball_left}, 32'd1);
        chk("g2_score07", {24'd0, score}, 32'h07);
        hit = 1'b1; miss = 1'b1;
        cyc(3);
        chk("hm_early", {30'd0, state}, {30'd0, S_PL});
        cyc(1);
        chk("hm_score", {24'd0, score}, 32'h08);
        chk("hm_state", {30'd0, state}, {30'd0, S_OV});
        hit = 1'b0; miss = 1'b0;
        wait_state(S_NG, 40, "hm_back_ng");

        // saturation at 99
        pulse_key();
        for (int i = 1; i <= 102; i++) begin
            pulse_hit();
            if (i == 20) chk("score_20", {24'd0, score}, 32'h20);
            if (i == 99) chk("score_99", {24'd0, score}, 32'h99);
        end
        chk("score_sat", {24'd0, score}, 32'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
